imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed little-endian program image as a
// byte stream and writes it, one 32-bit word at a time, into an instruction
// memory while holding the CPU in stall.
//
// Byte stream layout: N (16-bit little-endian word count), then 4*N data bytes,
// with each word sent least-significant byte first.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require one trailing
// byte equal to the XOR of all data bytes. A mismatch aborts the load with
// error=1. With the macro undefined, there is no checksum stage and the load
// finishes directly after the last word write.

module imem_loader #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE,
      DONE,
      ERR,
      CSUM
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE,
      DONE,
      ERR
   } state_t;
`endif

   state_t      state;
   logic [7:0]  len_lo;
   logic [15:0] word_len;
   logic [15:0] words_written;
   logic [1:0]  byte_cnt;
   logic [23:0] word_buf;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   logic        accept;
   logic [15:0] len_full;
   logic        len_too_big;

   // A byte moves only when both sides agree in the same cycle.
   assign accept      = byte_valid && byte_ready;
   // The full word count, valid on the cycle the high length byte is accepted.
   assign len_full    = {byte_data, len_lo};
   assign len_too_big = {16'd0, len_full} > 32'(DEPTH);

   // Load sequencer: state, the datapath registers and all registered outputs.
   // byte_ready is updated together with every state change, so it is high
   // exactly while the state is one that consumes bytes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         byte_ready    <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= 32'd0;
         cpu_hold      <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         len_lo        <= 8'd0;
         word_len      <= 16'd0;
         words_written <= 16'd0;
         byte_cnt      <= 2'd0;
         word_buf      <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum          <= 8'd0;
`endif
      end else begin
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state         <= LEN_LO;
                  byte_ready    <= 1'b1;
                  cpu_hold      <= 1'b1;
                  done          <= 1'b0;
                  error         <= 1'b0;
                  mem_addr      <= '0;
                  words_written <= 16'd0;
                  byte_cnt      <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum          <= 8'd0;
`endif
               end
            end

            LEN_LO: begin
               if (accept) begin
                  len_lo <= byte_data;
                  state  <= LEN_HI;
               end
            end

            LEN_HI: begin
               if (accept) begin
                  word_len <= len_full;
                  if (len_too_big) begin
                     state      <= ERR;
                     byte_ready <= 1'b0;
                     cpu_hold   <= 1'b0;
                     error      <= 1'b1;
                  end else if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state      <= CSUM;
`else
                     state      <= DONE;
                     byte_ready <= 1'b0;
                     cpu_hold   <= 1'b0;
                     done       <= 1'b1;
`endif
                  end else begin
                     state <= DATA;
                  end
               end
            end

            DATA: begin
               if (accept) begin
                  byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum     <= csum ^ byte_data;
`endif
                  case (byte_cnt)
                     2'd0: word_buf[7:0]   <= byte_data;
                     2'd1: word_buf[15:8]  <= byte_data;
                     2'd2: word_buf[23:16] <= byte_data;
                     default: begin
                        mem_wdata  <= {byte_data, word_buf};
                        mem_we     <= 1'b1;
                        byte_ready <= 1'b0;
                        state      <= WRITE;
                     end
                  endcase
               end
            end

            WRITE: begin
               // The address only advances when another word follows, so the
               // last word stays at N-1 and a full-depth load never wraps.
               mem_we        <= 1'b0;
               words_written <= words_written + 16'd1;
               if (words_written == word_len - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state      <= CSUM;
                  byte_ready <= 1'b1;
`else
                  state      <= DONE;
                  cpu_hold   <= 1'b0;
                  done       <= 1'b1;
`endif
               end else begin
                  mem_addr   <= mem_addr + ADDR_W'(1);
                  state      <= DATA;
                  byte_ready <= 1'b1;
               end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
               if (accept) begin
                  byte_ready <= 1'b0;
                  cpu_hold   <= 1'b0;
                  if (byte_data == csum) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ERR;
                     error <= 1'b1;
                  end
               end
            end
`endif

            default: begin
               state      <= IDLE;
               byte_ready <= 1'b0;
               mem_we     <= 1'b0;
               cpu_hold   <= 1'b0;
            end
         endcase
      end
   end

endmodule
